// File: rtl/round_robin_hold_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : round_robin_hold_arbiter_pkg
// Purpose : Shared type definitions for the round-robin hold arbiter.
//           Holds the two-state arbiter FSM encoding.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package round_robin_hold_arbiter_pkg;

  // IDLE: no grant outstanding. GRANTED: exactly one grant bit is set.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } arb_state_t;

endpackage : round_robin_hold_arbiter_pkg
`default_nettype wire

// File: rtl/round_robin_hold_arbiter_lsb.sv
`default_nettype none
// ============================================================================
// Module  : round_robin_hold_arbiter_lsb
// Purpose : Isolate the rightmost 1 bit of a word (x & (~x + 1)).
//           A zero input yields a zero output.
// Ports   : value  in  WIDTH  input word
//           lowest out WIDTH  one-hot lowest set bit of value, or zero
// Revision: 1.0 - initial release
// ============================================================================
module round_robin_hold_arbiter_lsb #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] lowest
);

  assign lowest = value & (~value + WIDTH'(1));

endmodule : round_robin_hold_arbiter_lsb
`default_nettype wire

// File: rtl/round_robin_hold_arbiter_mask.sv
`default_nettype none
// ============================================================================
// Module  : round_robin_hold_arbiter_mask
// Purpose : Turn on the trailing 0 bits of a value (x | (x - 1)).
//           Applied to a one-hot last grant, this sets the winner bit and
//           every bit below it; the caller inverts it to get the
//           thermometer of positions above the last winner.
// Ports   : value  in  WIDTH  input word (one-hot last grant)
//           filled out WIDTH  value with its trailing zeros set
// Revision: 1.0 - initial release
// ============================================================================
module round_robin_hold_arbiter_mask #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] filled
);

  assign filled = value | (value - WIDTH'(1));

endmodule : round_robin_hold_arbiter_mask
`default_nettype wire

// File: rtl/round_robin_hold_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : round_robin_hold_arbiter
// Purpose : Rotating-priority arbiter with a registered one-hot grant that is
//           held while its owner keeps requesting. An optional hold limit
//           forces rotation when others are waiting.
// Ports   : clock       in  1                rising-edge clock
//           clear       in  1                synchronous active-high reset
//           requests    in  REQUESTER_COUNT  level requests, bit i = requester i
//           grant       out REQUESTER_COUNT  registered one-hot grant or zero
//           grant_valid out 1                high when grant is non-zero
//           preempted   out 1                one-cycle pulse on forced rotation
// Revision: 1.0 - initial release
// ============================================================================
module round_robin_hold_arbiter
  import round_robin_hold_arbiter_pkg::*;
#(
  parameter int REQUESTER_COUNT = 4,
  parameter int MAX_HOLD_CYCLES = 16
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic [REQUESTER_COUNT-1:0] requests,
  output logic [REQUESTER_COUNT-1:0] grant,
  output logic                       grant_valid,
  output logic                       preempted
);

  localparam int N          = REQUESTER_COUNT;
  localparam int HOLD_WIDTH = (MAX_HOLD_CYCLES < 1) ? 1 : $clog2(MAX_HOLD_CYCLES + 1);
  // With no limit the counter simply parks at all-ones.
  localparam logic [HOLD_WIDTH-1:0] HOLD_SAT =
    (MAX_HOLD_CYCLES == 0) ? {HOLD_WIDTH{1'b1}} : HOLD_WIDTH'(MAX_HOLD_CYCLES);
  localparam logic [N-1:0] LAST_GRANT_RESET = {1'b1, {(N-1){1'b0}}};

  arb_state_t            state, state_next;
  logic [N-1:0]          last_grant, last_grant_next;
  logic [N-1:0]          grant_next;
  logic [HOLD_WIDTH-1:0] hold_count, hold_count_next;
  logic                  preempted_next;

  logic [N-1:0] filled;
  logic [N-1:0] mask;
  logic [N-1:0] masked_pick;
  logic [N-1:0] any_pick;
  logic [N-1:0] selection;
  logic         holder_active;
  logic         others_waiting;
  logic         limit_reached;

  // Positions strictly above the last winner get first chance.
  round_robin_hold_arbiter_mask #(.WIDTH(N)) u_mask (
    .value  (last_grant),
    .filled (filled)
  );
  assign mask = ~filled;

  round_robin_hold_arbiter_lsb #(.WIDTH(N)) u_lsb_masked (
    .value  (requests & mask),
    .lowest (masked_pick)
  );

  round_robin_hold_arbiter_lsb #(.WIDTH(N)) u_lsb_any (
    .value  (requests),
    .lowest (any_pick)
  );

  // Nothing requesting above the last winner: wrap to the lowest requester.
  assign selection      = (|(requests & mask)) ? masked_pick : any_pick;
  assign holder_active  = |(requests & grant);
  assign others_waiting = |(requests & ~grant);
  assign limit_reached  = (MAX_HOLD_CYCLES != 0) && (hold_count == HOLD_SAT);

  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    hold_count_next = hold_count;
    preempted_next  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (|requests) begin
          state_next      = ST_GRANTED;
          grant_next      = selection;
          last_grant_next = selection;
          hold_count_next = HOLD_WIDTH'(1);
        end
      end
      ST_GRANTED: begin
        if (!holder_active) begin
          if (|requests) begin
            // Hand off on the same edge, no idle cycle in between.
            grant_next      = selection;
            last_grant_next = selection;
            hold_count_next = HOLD_WIDTH'(1);
          end else begin
            state_next      = ST_IDLE;
            grant_next      = '0;
            hold_count_next = '0;
          end
        end else if (limit_reached && others_waiting) begin
          // The holder is last_grant, so selection cannot pick it again here.
          grant_next      = selection;
          last_grant_next = selection;
          hold_count_next = HOLD_WIDTH'(1);
          preempted_next  = 1'b1;
        end else if (hold_count != HOLD_SAT) begin
          hold_count_next = hold_count + HOLD_WIDTH'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= LAST_GRANT_RESET;
      hold_count <= '0;
      preempted  <= 1'b0;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
      hold_count <= hold_count_next;
      preempted  <= preempted_next;
    end
  end

  assign grant_valid = |grant;

endmodule : round_robin_hold_arbiter
`default_nettype wire

// File: tb/tb_round_robin_hold_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_round_robin_hold_arbiter
// Purpose : Self-checking bench for round_robin_hold_arbiter (4 requesters,
//           hold limit 4): directed vector table, multi-cycle sequences and
//           randomized requests against a circular-search reference model.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_round_robin_hold_arbiter;

  localparam int N    = 4;
  localparam int MAXH = 4;

  logic         clock;
  logic         clear;
  logic [N-1:0] requests;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic         preempted;

  int checks = 0;
  int errors = 0;

  // Reference model state: holder index (-1 = none), last winner, hold count.
  int   m_hold = -1;
  int   m_last = N - 1;
  int   m_cnt  = 0;
  logic m_pre  = 1'b0;

  round_robin_hold_arbiter #(
    .REQUESTER_COUNT (N),
    .MAX_HOLD_CYCLES (MAXH)
  ) dut (
    .clock       (clock),
    .clear       (clear),
    .requests    (requests),
    .grant       (grant),
    .grant_valid (grant_valid),
    .preempted   (preempted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         clr;
    logic [N-1:0] req;
    logic [N-1:0] g;
    logic         v;
    logic         p;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // First requester found searching upward from the one after the last winner.
  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] one;
    one = 1;
    return (m_hold < 0) ? '0 : (one << m_hold);
  endfunction

  task automatic model_update(input logic clr, input logic [N-1:0] req);
    logic [N-1:0] others;
    m_pre = 1'b0;
    if (clr) begin
      m_hold = -1;
      m_last = N - 1;
      m_cnt  = 0;
    end else if (m_hold < 0 || !req[m_hold]) begin
      if (req != '0) begin
        m_hold = rr_pick(req, m_last);
        m_last = m_hold;
        m_cnt  = 1;
      end else begin
        m_hold = -1;
        m_cnt  = 0;
      end
    end else begin
      others = req & ~model_grant();
      if (m_cnt >= MAXH && others != '0) begin
        m_hold = rr_pick(req, m_last);
        m_last = m_hold;
        m_cnt  = 1;
        m_pre  = 1'b1;
      end else if (m_cnt < MAXH) begin
        m_cnt++;
      end
    end
  endtask

  // Apply inputs away from the edge, then sample 1 time unit after it.
  task automatic step(input logic clr, input logic [N-1:0] req);
    @(negedge clock);
    clear    = clr;
    requests = req;
    @(posedge clock);
    model_update(clr, req);
    #1;
  endtask

  initial begin
    clear    = 1'b1;
    requests = '0;

    //               clr   req      grant    v     p
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0}; // reset state
    tbl[1]  = '{1'b0, 4'b0110, 4'b0010, 1'b1, 1'b0}; // basic grant
    tbl[2]  = '{1'b0, 4'b0101, 4'b0100, 1'b1, 1'b0}; // direct handoff
    tbl[3]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0}; // held
    tbl[4]  = '{1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0}; // handoff to MSB
    tbl[5]  = '{1'b0, 4'b0011, 4'b0001, 1'b1, 1'b0}; // wrap-around
    tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0}; // release to idle
    tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0}; // stay idle
    tbl[8]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0}; // above last winner 0001
    tbl[9]  = '{1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0}; // clear mid-grant
    tbl[10] = '{1'b0, 4'b1111, 4'b0001, 1'b1, 1'b0}; // bit 0 first after clear
    tbl[11] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0}; // release

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].clr, tbl[i].req);
      check($sformatf("tbl%0d grant", i), 32'(grant), 32'(tbl[i].g));
      check($sformatf("tbl%0d valid", i), 32'(grant_valid), 32'(tbl[i].v));
      check($sformatf("tbl%0d preempted", i), 32'(preempted), 32'(tbl[i].p));
    end

    // Forced rotation: two steady requesters alternate every MAXH cycles.
    step(1'b1, '0);
    for (int k = 1; k <= 12; k++) begin
      logic [N-1:0] eg;
      logic         ep;
      step(1'b0, 4'b0011);
      eg = (((k - 1) / MAXH) % 2 == 0) ? 4'b0001 : 4'b0010;
      ep = (k > 1) && ((k - 1) % MAXH == 0);
      check($sformatf("rot%0d grant", k), 32'(grant), 32'(eg));
      check($sformatf("rot%0d preempted", k), 32'(preempted), 32'(ep));
    end

    // Lone requester: never preempted, counter saturates at the limit.
    step(1'b1, '0);
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 4'b0100);
      check($sformatf("solo%0d grant", k), 32'(grant), 32'(4'b0100));
      check($sformatf("solo%0d preempted", k), 32'(preempted), 32'(1'b0));
      check($sformatf("solo%0d hold_count", k), 32'(dut.hold_count), (k < MAXH) ? k : MAXH);
    end

    // Randomized traffic against the reference model.
    step(1'b1, '0);
    for (int k = 0; k < 400; k++) begin
      logic         clr;
      logic [N-1:0] req;
      clr = ($urandom_range(0, 49) == 0);
      // Bias toward sparse requests so holds and releases both occur.
      req = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
      step(clr, req);
      check($sformatf("rnd%0d grant", k), 32'(grant), 32'(model_grant()));
      check($sformatf("rnd%0d valid", k), 32'(grant_valid), 32'(m_hold >= 0));
      check($sformatf("rnd%0d preempted", k), 32'(preempted), 32'(m_pre));
      check($sformatf("rnd%0d onehot", k), 32'($countones(grant) <= 1), 32'(1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_round_robin_hold_arbiter
`default_nettype wire
